// File: rtl/phys_reg_freelist_if.sv
// Shared sizing package and the rename/commit-side interface of the
// physical register free list.

package parameters;
  localparam int DISPATCH_WIDTH       = 2;
  localparam int PHYS_REGS            = 128;
  localparam int PHYS_REGS_ADDR_WIDTH = $clog2(PHYS_REGS);
endpackage

interface phys_reg_freelist_if;
  import parameters::*;

  logic [DISPATCH_WIDTH-1:0]                           alloc_req;
  logic                                                alloc_ready;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] alloc_preg;
  logic [DISPATCH_WIDTH-1:0]                           commit_alloc;
  logic [DISPATCH_WIDTH-1:0]                           free_en;
  logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] free_preg;
  logic                                                flush;
  logic [PHYS_REGS_ADDR_WIDTH:0]                       free_count;

  // Rename/ROB side drives requests, commits, releases and flush
  modport master (
    output alloc_req, commit_alloc, free_en, free_preg, flush,
    input  alloc_ready, alloc_preg, free_count
  );

  // Free list answers with tags and occupancy
  modport slave (
    input  alloc_req, commit_alloc, free_en, free_preg, flush,
    output alloc_ready, alloc_preg, free_count
  );
endinterface

// File: rtl/phys_reg_freelist.sv
// Circular free list of physical register tags with a speculative head
// (rename), a committed head (ROB commit) and a tail (released tags).
// A flush snaps the speculative head back to the committed head, which
// hands every squashed tag back in a single cycle.

module phys_reg_freelist
  import parameters::*;
(
  input  logic              clk,
  input  logic              rst_n,
  phys_reg_freelist_if.slave fl
);

  localparam int AW        = PHYS_REGS_ADDR_WIDTH;
  localparam int PW        = AW + 1;
  localparam int ARCH_REGS = 32;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [AW-1:0] tag_t;

  tag_t entries [PHYS_REGS];
  ptr_t spec_head;
  ptr_t commit_head;
  ptr_t tail;

  ptr_t free_count;
  logic alloc_ready;
  logic alloc_fire;
  ptr_t n_alloc;
  ptr_t n_commit;
  ptr_t n_free;
  ptr_t rd_ptr;
  ptr_t wr_ptr;
  tag_t wr_idx [DISPATCH_WIDTH];
  logic [DISPATCH_WIDTH-1:0][AW-1:0] alloc_tags;
  logic [DISPATCH_WIDTH-1:0] zero_free;

  // Number of set bits strictly below lane 'lane' (lane = width gives the total)
  function automatic ptr_t count_below(input logic [DISPATCH_WIDTH-1:0] bits, input int lane);
    ptr_t n;
    n = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (i < lane && bits[i]) n = n + ptr_t'(1);
    end
    return n;
  endfunction

  assign free_count  = tail - spec_head;
  assign alloc_ready = (free_count >= ptr_t'(DISPATCH_WIDTH));
  assign alloc_fire  = alloc_ready && !fl.flush;
  assign n_alloc     = count_below(fl.alloc_req, DISPATCH_WIDTH);
  assign n_commit    = count_below(fl.commit_alloc, DISPATCH_WIDTH);
  assign n_free      = count_below(fl.free_en, DISPATCH_WIDTH);

  assign fl.free_count  = free_count;
  assign fl.alloc_ready = alloc_ready;
  assign fl.alloc_preg  = alloc_tags;

  // Read tags for each lane: requesting lanes are compacted, idle lanes show entry[head+k]
  always_comb begin
    alloc_tags = '0;
    rd_ptr     = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (fl.alloc_req[k]) rd_ptr = spec_head + count_below(fl.alloc_req, k);
      else                 rd_ptr = spec_head + ptr_t'(k);
      alloc_tags[k] = entries[rd_ptr[AW-1:0]];
    end
  end

  // Compacted write slots for released tags starting at the tail
  always_comb begin
    wr_ptr = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      wr_ptr    = tail + count_below(fl.free_en, k);
      wr_idx[k] = wr_ptr[AW-1:0];
    end
  end

  // Tag storage: reset seeds the unmapped tags, released tags land at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHYS_REGS; i++) begin
        entries[i] <= (i < PHYS_REGS - ARCH_REGS) ? tag_t'(ARCH_REGS + i) : '0;
      end
    end else begin
      for (int k = 0; k < DISPATCH_WIDTH; k++) begin
        if (fl.free_en[k]) entries[wr_idx[k]] <= fl.free_preg[k];
      end
    end
  end

  // Pointer updates: flush restores the speculative head past this cycle's commits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_head   <= '0;
      commit_head <= '0;
      tail        <= ptr_t'(PHYS_REGS - ARCH_REGS);
    end else begin
      commit_head <= commit_head + n_commit;
      tail        <= tail + n_free;
      if (fl.flush)        spec_head <= commit_head + n_commit;
      else if (alloc_fire) spec_head <= spec_head + n_alloc;
    end
  end

  // Flag enabled lanes that try to release tag 0
  always_comb begin
    zero_free = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      zero_free[k] = fl.free_en[k] && (fl.free_preg[k] == '0);
    end
  end

  a_tail_commit_span: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_t'(tail - commit_head) <= ptr_t'(PHYS_REGS));
  a_commit_behind_spec: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_t'(spec_head - commit_head) <= ptr_t'(PHYS_REGS));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    free_count <= ptr_t'(PHYS_REGS));
  a_no_tag_zero_free: assert property (@(posedge clk) disable iff (!rst_n)
    zero_free == '0);

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Bench for phys_reg_freelist: a queue-based model of the free list
// (free queue, in-flight queue, mapped set) is compared against the DUT
// every cycle, with directed scenarios pinned by literal expectations.

module tb_phys_reg_freelist;
  import parameters::*;

  localparam int DW = DISPATCH_WIDTH;
  localparam int AW = PHYS_REGS_ADDR_WIDTH;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  bit   armed = 1'b0;

  int n_vectors     = 0;
  int n_miscompares = 0;

  int free_q[$];
  int inflight_q[$];
  int mapped_q[$];

  phys_reg_freelist_if fl_if ();

  phys_reg_freelist dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fl    (fl_if)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual != expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    free_q.delete();
    inflight_q.delete();
    mapped_q.delete();
    for (int t = 32; t < PHYS_REGS; t++) free_q.push_back(t);
    for (int t = 0; t < 32; t++) mapped_q.push_back(t);
  endfunction

  function automatic void unmap(input int t);
    for (int i = 0; i < mapped_q.size(); i++) begin
      if (mapped_q[i] == t) begin
        mapped_q.delete(i);
        break;
      end
    end
  endfunction

  function automatic int outstanding(input int t);
    int n;
    n = 0;
    foreach (inflight_q[i]) if (inflight_q[i] == t) n++;
    foreach (mapped_q[i]) if (mapped_q[i] == t) n++;
    return n;
  endfunction

  function automatic void model_step();
    bit ready;
    ready = (free_q.size() >= DW);
    for (int k = 0; k < DW; k++) begin
      if (fl_if.commit_alloc[k] && inflight_q.size() > 0) mapped_q.push_back(inflight_q.pop_front());
    end
    if (fl_if.flush) begin
      while (inflight_q.size() > 0) free_q.push_front(inflight_q.pop_back());
    end else if (ready) begin
      for (int k = 0; k < DW; k++) begin
        if (fl_if.alloc_req[k] && free_q.size() > 0) inflight_q.push_back(free_q.pop_front());
      end
    end
    for (int k = 0; k < DW; k++) begin
      if (fl_if.free_en[k]) begin
        unmap(int'(fl_if.free_preg[k]));
        free_q.push_back(int'(fl_if.free_preg[k]));
      end
    end
  endfunction

  // Advance the model on each clock edge; reset it with the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare DUT outputs against the model mid-cycle
  always @(negedge clk) begin : compare
    int idx;
    int t;
    if (armed && rst_n) begin
      check_output("free_count", int'(fl_if.free_count), free_q.size());
      check_output("alloc_ready", int'(fl_if.alloc_ready), int'(free_q.size() >= DW));
      if (free_q.size() >= DW) begin
        idx = 0;
        for (int k = 0; k < DW; k++) begin
          if (fl_if.alloc_req[k]) begin
            t = int'(fl_if.alloc_preg[k]);
            check_output($sformatf("alloc_preg[%0d]", k), t, free_q[idx]);
            check_output($sformatf("dup_tag[%0d]", k), outstanding(t), 0);
            idx++;
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [DW-1:0] req, input logic [DW-1:0] calloc,
                                input logic [DW-1:0] fen, input int fp0, input int fp1,
                                input logic fl);
    logic [31:0] p0;
    logic [31:0] p1;
    p0 = fp0;
    p1 = fp1;
    fl_if.alloc_req    = req;
    fl_if.commit_alloc = calloc;
    fl_if.free_en      = fen;
    fl_if.free_preg[0] = p0[AW-1:0];
    fl_if.free_preg[1] = p1[AW-1:0];
    fl_if.flush        = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply_stimulus('0, '0, '0, 1, 1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    armed = 1'b1;
  endtask

  task automatic check_reset_state();
    apply_stimulus('0, '0, '0, 1, 1, 1'b0);
    check_output("reset_free_count", int'(fl_if.free_count), 96);
    check_output("reset_alloc_ready", int'(fl_if.alloc_ready), 1);
    check_output("reset_alloc_preg0", int'(fl_if.alloc_preg[0]), 32);
    check_output("reset_alloc_preg1", int'(fl_if.alloc_preg[1]), 33);
  endtask

  // One legal random cycle: commits free an old mapped tag each
  task automatic random_cycle();
    int max_c;
    int n_c;
    int picks[2];
    int start;
    int cand;
    logic [DW-1:0] req;
    logic [DW-1:0] calloc;
    logic fl;
    req   = 2'($urandom_range(0, 3));
    max_c = (inflight_q.size() < 2) ? inflight_q.size() : 2;
    n_c   = ($urandom_range(0, 3) != 0) ? max_c : $urandom_range(0, max_c);
    if (n_c == 2)      calloc = 2'b11;
    else if (n_c == 1) calloc = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
    else               calloc = 2'b00;
    picks[0] = 1;
    picks[1] = 1;
    for (int p = 0; p < n_c; p++) begin
      start = $urandom_range(0, mapped_q.size() - 1);
      for (int s = 0; s < mapped_q.size(); s++) begin
        cand = mapped_q[(start + s) % mapped_q.size()];
        if (cand != 0 && (p == 0 || cand != picks[0])) begin
          picks[p] = cand;
          break;
        end
      end
    end
    if (calloc == 2'b10) begin
      picks[1] = picks[0];
      picks[0] = 1;
    end
    fl = ($urandom_range(0, 19) == 0);
    apply_stimulus(req, calloc, calloc, picks[0], picks[1], fl);
    tick();
  endtask

  initial begin
    fl_if.alloc_req    = '0;
    fl_if.commit_alloc = '0;
    fl_if.free_en      = '0;
    fl_if.free_preg    = '0;
    fl_if.flush        = 1'b0;

    // Drain the list from reset, two tags per cycle
    do_reset();
    check_reset_state();
    for (int c = 0; c < 48; c++) begin
      apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
      if (c == 0) begin
        check_output("drain_first_lane0", int'(fl_if.alloc_preg[0]), 32);
        check_output("drain_first_lane1", int'(fl_if.alloc_preg[1]), 33);
      end
      if (c == 47) begin
        check_output("drain_last_lane0", int'(fl_if.alloc_preg[0]), 126);
        check_output("drain_last_lane1", int'(fl_if.alloc_preg[1]), 127);
      end
      tick();
    end
    apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
    check_output("empty_free_count", int'(fl_if.free_count), 0);
    check_output("empty_alloc_ready", int'(fl_if.alloc_ready), 0);
    tick();
    apply_stimulus('0, '0, '0, 1, 1, 1'b0);
    check_output("empty_stays_empty", int'(fl_if.free_count), 0);

    // Gap in the request vector does not waste a tag
    do_reset();
    apply_stimulus(2'b10, '0, '0, 1, 1, 1'b0);
    check_output("gap_lane1", int'(fl_if.alloc_preg[1]), 32);
    tick();
    apply_stimulus('0, '0, '0, 1, 1, 1'b0);
    check_output("gap_next_lane0", int'(fl_if.alloc_preg[0]), 33);
    check_output("gap_free_count", int'(fl_if.free_count), 95);
    tick();

    // Free with only one tag left: alloc stalls, tag visible next cycle
    do_reset();
    for (int c = 0; c < 47; c++) begin
      apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
      tick();
    end
    apply_stimulus(2'b01, '0, '0, 1, 1, 1'b0);
    tick();
    apply_stimulus(2'b01, '0, 2'b01, 5, 1, 1'b0);
    check_output("low_free_count", int'(fl_if.free_count), 1);
    check_output("low_alloc_ready", int'(fl_if.alloc_ready), 0);
    tick();
    apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
    check_output("refill_free_count", int'(fl_if.free_count), 2);
    check_output("refill_alloc_ready", int'(fl_if.alloc_ready), 1);
    check_output("refill_lane0", int'(fl_if.alloc_preg[0]), 127);
    check_output("refill_lane1", int'(fl_if.alloc_preg[1]), 5);
    tick();

    // Allocate six, commit two, flush: the squashed four come back
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
      tick();
    end
    apply_stimulus('0, 2'b11, '0, 1, 1, 1'b0);
    tick();
    apply_stimulus('0, '0, '0, 1, 1, 1'b1);
    tick();
    apply_stimulus(2'b01, '0, '0, 1, 1, 1'b0);
    check_output("flush_lane0", int'(fl_if.alloc_preg[0]), 34);
    check_output("flush_free_count", int'(fl_if.free_count), 94);
    tick();

    // Flush with same-cycle commit and frees of 7 and 9
    do_reset();
    for (int c = 0; c < 2; c++) begin
      apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
      tick();
    end
    apply_stimulus('0, 2'b01, 2'b11, 7, 9, 1'b1);
    tick();
    apply_stimulus('0, '0, '0, 1, 1, 1'b0);
    check_output("mix_free_count", int'(fl_if.free_count), 97);
    check_output("mix_lane0", int'(fl_if.alloc_preg[0]), 33);
    for (int c = 0; c < 48; c++) begin
      apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
      if (c == 47) begin
        check_output("mix_tail_lane0", int'(fl_if.alloc_preg[0]), 127);
        check_output("mix_tail_lane1", int'(fl_if.alloc_preg[1]), 7);
      end
      tick();
    end
    apply_stimulus('0, '0, 2'b01, 11, 1, 1'b0);
    tick();
    apply_stimulus(2'b11, '0, '0, 1, 1, 1'b0);
    check_output("mix_last_lane0", int'(fl_if.alloc_preg[0]), 9);
    check_output("mix_last_lane1", int'(fl_if.alloc_preg[1]), 11);
    tick();

    // Random traffic long enough to wrap the pointers, with a mid-run reset
    do_reset();
    for (int c = 0; c < 380; c++) random_cycle();
    do_reset();
    check_reset_state();
    tick();
    for (int c = 0; c < 20; c++) random_cycle();

    apply_stimulus('0, '0, '0, 1, 1, 1'b0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
